ir_packet_tx: RTL and testbench



---
 rtl/ir_packet_tx.sv | 131 +++++++++++++
 tb/tb_ir_packet_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_packet_tx.sv
// IR car-control packet framer: serialises a latched 4-bit drive command as
// pulse-width-coded 36 kHz carrier bursts separated by silent gaps.
module ir_packet_tx #(
    parameter int CARRIER_HALF = 1389,
    parameter int START_LEN    = 192,
    parameter int SELECT_LEN   = 24,
    parameter int GAP_LEN      = 25,
    parameter int ASSERT_LEN   = 48,
    parameter int DEASSERT_LEN = 24
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SEND_PACKET,
    input  logic [3:0] COMMAND,
    output logic       IR_LED,
    output logic       BUSY,
    output logic       DONE
);
    // state  | meaning
    // IDLE   | waiting for SEND_PACKET, LED dark
    // START  | START burst
    // GAPn   | silent gap between bursts
    // SELECT | CAR_SELECT burst
    // RIGHT  | command bit 3 burst
    // LEFT   | command bit 2 burst
    // BACK   | command bit 1 burst
    // FWD    | command bit 0 burst, last segment
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_GAP1, S_SELECT, S_GAP2, S_RIGHT,
        S_GAP3, S_LEFT, S_GAP4, S_BACK, S_GAP5, S_FWD
    } state_t;

    localparam int MAX_A   = (START_LEN > SELECT_LEN) ? START_LEN : SELECT_LEN;
    localparam int MAX_B   = (GAP_LEN > MAX_A) ? GAP_LEN : MAX_A;
    localparam int MAX_C   = (ASSERT_LEN > MAX_B) ? ASSERT_LEN : MAX_B;
    localparam int MAX_LEN = (DEASSERT_LEN > MAX_C) ? DEASSERT_LEN : MAX_C;
    localparam int HALF_W  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam int PER_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CARRIER_HALF - 1);
    localparam logic [PER_W-1:0]  START_M1   = PER_W'(START_LEN - 1);
    localparam logic [PER_W-1:0]  SELECT_M1  = PER_W'(SELECT_LEN - 1);
    localparam logic [PER_W-1:0]  GAP_M1     = PER_W'(GAP_LEN - 1);
    localparam logic [PER_W-1:0]  ASSERT_M1  = PER_W'(ASSERT_LEN - 1);
    localparam logic [PER_W-1:0]  DEASSERT_M1 = PER_W'(DEASSERT_LEN - 1);

    state_t            state;
    state_t            next_seg;
    logic [HALF_W-1:0] half_cnt;
    logic              phase;
    logic [PER_W-1:0]  per_cnt;
    logic [3:0]        cmd_q;
    logic [PER_W-1:0]  len_m1;
    logic              cur_burst;
    logic              next_burst;
    logic              half_end;
    logic              seg_end;

    // Per-segment length (minus one), successor and burst/gap flag
    always_comb begin
        len_m1    = '0;
        next_seg  = S_IDLE;
        cur_burst = 1'b0;
        case (state)
            S_START:  begin len_m1 = START_M1;  next_seg = S_GAP1;   cur_burst = 1'b1; end
            S_GAP1:   begin len_m1 = GAP_M1;    next_seg = S_SELECT; end
            S_SELECT: begin len_m1 = SELECT_M1; next_seg = S_GAP2;   cur_burst = 1'b1; end
            S_GAP2:   begin len_m1 = GAP_M1;    next_seg = S_RIGHT;  end
            S_RIGHT:  begin len_m1 = cmd_q[3] ? ASSERT_M1 : DEASSERT_M1; next_seg = S_GAP3; cur_burst = 1'b1; end
            S_GAP3:   begin len_m1 = GAP_M1;    next_seg = S_LEFT;   end
            S_LEFT:   begin len_m1 = cmd_q[2] ? ASSERT_M1 : DEASSERT_M1; next_seg = S_GAP4; cur_burst = 1'b1; end
            S_GAP4:   begin len_m1 = GAP_M1;    next_seg = S_BACK;   end
            S_BACK:   begin len_m1 = cmd_q[1] ? ASSERT_M1 : DEASSERT_M1; next_seg = S_GAP5; cur_burst = 1'b1; end
            S_GAP5:   begin len_m1 = GAP_M1;    next_seg = S_FWD;    end
            S_FWD:    begin len_m1 = cmd_q[0] ? ASSERT_M1 : DEASSERT_M1; next_seg = S_IDLE; cur_burst = 1'b1; end
            default:  begin len_m1 = '0;        next_seg = S_IDLE;   end
        endcase
        next_burst = (next_seg == S_SELECT) || (next_seg == S_RIGHT) || (next_seg == S_LEFT) ||
                     (next_seg == S_BACK)   || (next_seg == S_FWD);
        half_end   = (half_cnt == HALF_LAST);
        seg_end    = half_end && phase && (per_cnt == len_m1);
    end

    // IR_LED is driven from the post-edge phase so the LED matches the counters
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= S_IDLE;
            half_cnt <= '0;
            phase    <= 1'b0;
            per_cnt  <= '0;
            cmd_q    <= 4'b0000;
            IR_LED   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (state == S_IDLE) begin
                half_cnt <= '0;
                phase    <= 1'b0;
                per_cnt  <= '0;
                IR_LED   <= 1'b0;
                if (SEND_PACKET) begin
                    cmd_q  <= COMMAND;
                    state  <= S_START;
                    BUSY   <= 1'b1;
                    IR_LED <= 1'b1;
                end
            end else if (seg_end) begin
                half_cnt <= '0;
                phase    <= 1'b0;
                per_cnt  <= '0;
                state    <= next_seg;
                IR_LED   <= next_burst;
                if (next_seg == S_IDLE) begin
                    BUSY <= 1'b0;
                    DONE <= 1'b1;
                end
            end else if (half_end) begin
                half_cnt <= '0;
                phase    <= ~phase;
                if (phase) begin
                    per_cnt <= per_cnt + 1'b1;
                end
                IR_LED <= cur_burst && phase;
            end else begin
                half_cnt <= half_cnt + 1'b1;
                IR_LED   <= cur_burst && !phase;
            end
        end
    end
endmodule

// File: tb/tb_ir_packet_tx.sv
// Bench for ir_packet_tx: directed vector table, corner sequences and random
// commands checked against a waveform model built from the segment list.
module tb_ir_packet_tx;
    localparam int CH  = 2;
    localparam int STL = 4;
    localparam int SEL = 2;
    localparam int GPL = 1;
    localparam int ASL = 3;
    localparam int DSL = 1;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       SEND_PACKET;
    logic [3:0] COMMAND;
    logic       IR_LED;
    logic       BUSY;
    logic       DONE;

    always #5 CLK = ~CLK;

    ir_packet_tx #(
        .CARRIER_HALF(CH), .START_LEN(STL), .SELECT_LEN(SEL),
        .GAP_LEN(GPL), .ASSERT_LEN(ASL), .DEASSERT_LEN(DSL)
    ) dut (
        .CLK(CLK), .RESET(RESET), .SEND_PACKET(SEND_PACKET), .COMMAND(COMMAND),
        .IR_LED(IR_LED), .BUSY(BUSY), .DONE(DONE)
    );

    typedef struct {
        logic [3:0] cmd;
        int         busy;
        int         rises;
        int         highs;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];
    int mdl_rises;
    int mdl_highs;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected IR_LED sequence: alternating burst/gap segments, each period high then low
    task automatic build_model(input logic [3:0] cmd);
        int  seg[11];
        bit  prev;
        seg = '{STL, GPL, SEL, GPL, (cmd[3] ? ASL : DSL), GPL, (cmd[2] ? ASL : DSL),
                GPL, (cmd[1] ? ASL : DSL), GPL, (cmd[0] ? ASL : DSL)};
        exp_q.delete();
        for (int s = 0; s < 11; s++)
            for (int p = 0; p < seg[s]; p++)
                for (int h = 0; h < 2 * CH; h++)
                    exp_q.push_back((s % 2 == 0) && (h < CH));
        mdl_rises = 0;
        mdl_highs = 0;
        prev = 1'b0;
        foreach (exp_q[i]) begin
            if (exp_q[i] && !prev) mdl_rises++;
            if (exp_q[i]) mdl_highs++;
            prev = exp_q[i];
        end
    endtask

    // Observes one packet from its first busy cycle; returns in the DONE cycle
    task automatic run_packet(input logic [3:0] cmd, input bit do_send, input bit spam,
                              output int blen, output int rises, output int highs,
                              output int werr, output int done_v, output int led_v);
        int k;
        bit prev;
        if (do_send) begin
            COMMAND     = cmd;
            SEND_PACKET = 1'b1;
            tick();
            SEND_PACKET = 1'b0;
        end
        k = 0; rises = 0; highs = 0; werr = 0; prev = 1'b0;
        while (BUSY && k < 400) begin
            if (k >= exp_q.size() || IR_LED !== exp_q[k]) werr++;
            if (DONE) werr++;
            if (IR_LED && !prev) rises++;
            if (IR_LED) highs++;
            prev = IR_LED;
            if (spam) begin
                SEND_PACKET = (k == 9 || k == 39);
                if (k == 20) COMMAND = 4'b1111;
            end
            tick();
            k++;
        end
        SEND_PACKET = 1'b0;
        blen   = k;
        done_v = int'(DONE);
        led_v  = int'(IR_LED);
    endtask

    initial begin
        vec_t vecs[5];
        int blen, rises, highs, werr, done_v, led_v, bad;
        logic [3:0] rc;

        vecs[0] = '{4'b0101, 76, 14, 28};
        vecs[1] = '{4'b0000, 60, 10, 20};
        vecs[2] = '{4'b1111, 92, 18, 36};
        vecs[3] = '{4'b1000, 68, 12, 24};
        vecs[4] = '{4'b0011, 76, 14, 28};

        RESET = 1'b0; SEND_PACKET = 1'b0; COMMAND = 4'b0000;
        repeat (3) tick();
        check("reset_ir_led", int'(IR_LED), 0);
        check("reset_busy", int'(BUSY), 0);
        check("reset_done", int'(DONE), 0);
        RESET = 1'b1;
        tick();

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (IR_LED !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) bad++;
            tick();
        end
        check("idle_quiet_cycles", bad, 0);

        for (int v = 0; v < 5; v++) begin
            build_model(vecs[v].cmd);
            run_packet(vecs[v].cmd, 1'b1, 1'b0, blen, rises, highs, werr, done_v, led_v);
            check("vec_busy_len", blen, vecs[v].busy);
            check("vec_rises", rises, vecs[v].rises);
            check("vec_highs", highs, vecs[v].highs);
            check("vec_wave_errs", werr, 0);
            check("vec_done_pulse", done_v, 1);
            check("vec_led_idle", led_v, 0);
            tick();
            check("vec_done_one_cycle", int'(DONE), 0);
            repeat (3) tick();
        end

        // Strobes and command change while busy must not disturb the packet
        build_model(4'b0101);
        run_packet(4'b0101, 1'b1, 1'b1, blen, rises, highs, werr, done_v, led_v);
        check("spam_busy_len", blen, 76);
        check("spam_wave_errs", werr, 0);
        check("spam_done_pulse", done_v, 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (BUSY !== 1'b0 || IR_LED !== 1'b0) bad++;
        end
        check("spam_no_second_packet", bad, 0);

        // Reset at packet cycle 30 aborts without DONE
        COMMAND = 4'b0101; SEND_PACKET = 1'b1;
        tick();
        SEND_PACKET = 1'b0;
        repeat (30) tick();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        check("abort_ir_led", int'(IR_LED), 0);
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (DONE !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        check("abort_no_done_later", bad, 0);
        build_model(4'b0110);
        run_packet(4'b0110, 1'b1, 1'b0, blen, rises, highs, werr, done_v, led_v);
        check("after_abort_busy_len", blen, exp_q.size());
        check("after_abort_wave_errs", werr, 0);
        check("after_abort_done", done_v, 1);
        tick();

        // Back-to-back: strobe during the DONE cycle
        build_model(4'b0011);
        run_packet(4'b0011, 1'b1, 1'b0, blen, rises, highs, werr, done_v, led_v);
        check("chain1_busy_len", blen, 76);
        check("chain1_done", done_v, 1);
        COMMAND = 4'b1000; SEND_PACKET = 1'b1;
        tick();
        SEND_PACKET = 1'b0;
        check("chain2_busy_start", int'(BUSY), 1);
        check("chain2_led_start", int'(IR_LED), 1);
        check("chain2_done_low", int'(DONE), 0);
        build_model(4'b1000);
        run_packet(4'b1000, 1'b0, 1'b0, blen, rises, highs, werr, done_v, led_v);
        check("chain2_busy_len", blen, 68);
        check("chain2_wave_errs", werr, 0);
        check("chain2_done", done_v, 1);
        tick();

        for (int r = 0; r < 20; r++) begin
            rc = 4'($urandom_range(0, 15));
            build_model(rc);
            run_packet(rc, 1'b1, 1'b0, blen, rises, highs, werr, done_v, led_v);
            check("rand_busy_len", blen, exp_q.size());
            check("rand_wave_errs", werr, 0);
            check("rand_rises", rises, mdl_rises);
            check("rand_highs", highs, mdl_highs);
            check("rand_done", done_v, 1);
            tick();
            repeat ($urandom_range(0, 5)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
